traffic_phase_ctrl: RTL and testbench
=====================================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter N_PHASE, default 4: number of signal phases (2..8).
REQ-002 Parameter TW, default 6: timer and green-time width in bits.
REQ-003 Parameter Y_TIME, default 3: yellow duration in TICKs.
REQ-004 Parameter R_TIME, default 1: all-red clearance duration in TICKs (minimum 1).
REQ-005 CLK  in  1  system clock; one clock; all state changes on its rising edge.
REQ-006 RSTn  in  1  reset, asynchronous, active-low.
REQ-007 TICK  in  1  one-cycle timebase enable (1 Hz in system use).
REQ-008 REQ  in  N_PHASE  per-phase demand; bit i=1 means traffic is waiting on phase i.
REQ-009 GREEN_T  in  N_PHASE*TW  per-phase green time; slice i is bits [i*TW +: TW].
REQ-010 NIGHT  in  1  flashing-yellow night mode request.
REQ-011 state  out  2  GREEN=00, YELLOW=01, ALLRED=10, FLASH=11.
REQ-012 phase  out  3  index of the current or last-green phase.
REQ-013 remain  out  TW  seconds left in the current interval.
REQ-014 green, yellow, red  out  N_PHASE each  per-phase lamp drives.

Function
REQ-015 Expiry event: TICK=1 while remain==1; on a TICK with remain>1, remain decrements by 1; without TICK, remain holds.
REQ-016 On entering GREEN for phase p, remain loads GREEN_T[p]; a value of 0 loads as 1.
REQ-017 On GREEN expiry: if any REQ bit other than phase is set, go to YELLOW with remain=Y_TIME and latch nxt.
REQ-018 On GREEN expiry with no other REQ bit set, stay in GREEN and reload GREEN_T[phase] (demand-held extension).
REQ-019 nxt is the first index after phase, searching upward with wrap-around modulo N_PHASE, whose REQ bit is 1.
REQ-020 REQ is sampled only in the expiry cycle; demand dropped before expiry is ignored.
REQ-021 On YELLOW expiry, go to ALLRED with remain=R_TIME.
REQ-022 On ALLRED expiry, go to GREEN with phase=nxt.
REQ-023 Lamp decode:
- GREEN: green[phase]=1, red on all other phases.
- YELLOW: yellow[phase]=1, red on all other phases.
- ALLRED: red on all phases.
- Lamps are decoded from registers only; there is no combinational path from any input.
REQ-024 NIGHT=1 forces FLASH on the next clock edge from any state, taking priority over an expiry in the same cycle.
REQ-025 In FLASH:
- Red and green are all 0.
- All yellow bits equal a flash bit that toggles on each TICK; the flash bit is 1 on FLASH entry.
- remain=0.
REQ-026 In FLASH with NIGHT=0, go to ALLRED with remain=R_TIME and nxt=0.
REQ-027 Exactly one of green/yellow/red is active per phase outside FLASH; no two phases are ever green together.

Reset
REQ-028 RSTn low immediately sets the following, regardless of CLK:
- state=ALLRED, phase=0, nxt=0, remain=R_TIME, flash bit=0.
- All red=1, all green=0, all yellow=0.
REQ-029 Reset asserted mid-interval abandons the interval; the first green after release is phase 0, after R_TIME TICKs.

Structure
REQ-030 The shared package holds:
- the state encoding constants;
- the default values of Y_TIME and R_TIME;
- the lamp-vector index helpers.
REQ-031 The countdown (load, decrement on TICK, expiry flag) is one sub-module, phase_timer, parametrised by TW.
REQ-032 The round-robin next-phase search is a combinational function in the top module.

Verification (N_PHASE=4, TW=6, Y_TIME=3, R_TIME=1, TICK=1 every cycle, GREEN_T={8,7,6,5} for phases 3..0)
REQ-033 Reset release with REQ=0 -> one cycle in ALLRED with red=1111, then GREEN with phase 0, green=0001, remain=5.
REQ-034 REQ=0000 held -> phase 0 stays green; remain runs 5,4,3,2,1,5,... indefinitely.
REQ-035 REQ=1010 at phase-0 expiry -> YELLOW with remain 3,2,1, then ALLRED for 1 cycle, then phase 1 green with remain=6; next switch goes to phase 3.
REQ-036 From phase 2 green with REQ=0001 -> wrap-around selects phase 0.
REQ-037 NIGHT=1 mid-GREEN -> FLASH next cycle with yellow=1111, then 0000 alternating per TICK; NIGHT=0 -> ALLRED for 1 cycle, then phase 0 green.
REQ-038 RSTn pulsed low mid-YELLOW of phase 2 -> same cycle red=1111, state=ALLRED, remain=1; phase 0 green after release.

Source files
------------

// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared definitions for the traffic phase controller: state encoding,
// default interval lengths and lamp-vector index helpers.
package traffic_phase_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_GREEN  = 2'b00,
      ST_YELLOW = 2'b01,
      ST_ALLRED = 2'b10,
      ST_FLASH  = 2'b11
   } state_e;

   localparam int unsigned MAX_PHASE  = 8;
   localparam int unsigned PHASE_W    = 3;
   localparam int unsigned Y_TIME_DEF = 3;
   localparam int unsigned R_TIME_DEF = 1;

   // One-hot lamp vector for a phase index, sized for the largest phase count.
   function automatic logic [MAX_PHASE-1:0] phase_onehot(input logic [PHASE_W-1:0] p);
      return MAX_PHASE'(1) << p;
   endfunction

   // Bit offset of a phase's slice in a packed per-phase field of width tw.
   function automatic int unsigned green_lsb(input logic [PHASE_W-1:0] p, input int unsigned tw);
      return 32'(p) * tw;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Interval countdown: load has priority, otherwise decrement on each tick
// down to 1; expiry is a tick seen while the count is 1.
module phase_timer #(
   parameter int unsigned TW      = 6,
   parameter int unsigned RST_VAL = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_tick,
   input  logic          i_load,
   input  logic [TW-1:0] i_load_val,
   output logic [TW-1:0] o_remain,
   output logic          o_expire_c
);

   logic [TW-1:0] r_remain;

   assign o_expire_c = i_tick && (r_remain == TW'(1));
   assign o_remain   = r_remain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_remain <= TW'(RST_VAL);
      end else if (i_load) begin
         r_remain <= i_load_val;
      end else if (i_tick && (r_remain > TW'(1))) begin
         r_remain <= r_remain - TW'(1);
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin traffic signal controller with green/yellow/all-red cycling,
// demand-held green extension and a flashing-yellow night mode.
module traffic_phase_ctrl
   import traffic_phase_ctrl_pkg::*;
#(
   parameter int unsigned N_PHASE = 4,
   parameter int unsigned TW      = 6,
   parameter int unsigned Y_TIME  = Y_TIME_DEF,
   parameter int unsigned R_TIME  = R_TIME_DEF
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic                  TICK,
   input  logic [N_PHASE-1:0]    REQ,
   input  logic [N_PHASE*TW-1:0] GREEN_T,
   input  logic                  NIGHT,
   output logic [1:0]            state,
   output logic [2:0]            phase,
   output logic [TW-1:0]         remain,
   output logic [N_PHASE-1:0]    green,
   output logic [N_PHASE-1:0]    yellow,
   output logic [N_PHASE-1:0]    red
);

   state_e               r_state,  w_state_d;
   logic [2:0]           r_phase,  w_phase_d;
   logic [2:0]           r_nxt,    w_nxt_d;
   logic                 r_flash,  w_flash_d;
   logic [N_PHASE-1:0]   r_green,  w_green_d;
   logic [N_PHASE-1:0]   r_yellow, w_yellow_d;
   logic [N_PHASE-1:0]   r_red,    w_red_d;
   logic [N_PHASE-1:0]   w_phase_oh;
   logic                 w_other_req;
   logic                 w_load;
   logic [TW-1:0]        w_load_val;
   logic                 w_expire;

   // Green time for a phase; a programmed zero still gives one tick.
   function automatic logic [TW-1:0] f_green_time(input logic [N_PHASE*TW-1:0] gt,
                                                  input logic [2:0] p);
      logic [TW-1:0] t;
      t = gt[green_lsb(p, TW) +: TW];
      return (t == '0) ? TW'(1) : t;
   endfunction

   // First phase after cur, searching upward with wrap, that has demand.
   function automatic logic [2:0] f_next_phase(input logic [N_PHASE-1:0] req,
                                               input logic [2:0] cur);
      logic [2:0]  nxt;
      logic        found;
      int unsigned idx;
      nxt   = cur;
      found = 1'b0;
      for (int unsigned k = 1; k < N_PHASE; k++) begin
         idx = (32'(cur) + k) % N_PHASE;
         if (!found && req[idx]) begin
            nxt   = 3'(idx);
            found = 1'b1;
         end
      end
      return nxt;
   endfunction

   assign w_other_req = |(REQ & ~N_PHASE'(phase_onehot(r_phase)));

   phase_timer #(
      .TW      (TW),
      .RST_VAL (R_TIME)
   ) u_timer (
      .clk        (CLK),
      .rst_n      (RSTn),
      .i_tick     (TICK),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_remain   (remain),
      .o_expire_c (w_expire)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state  <= ST_ALLRED;
         r_phase  <= '0;
         r_nxt    <= '0;
         r_flash  <= 1'b0;
         r_green  <= '0;
         r_yellow <= '0;
         r_red    <= '1;
      end else begin
         r_state  <= w_state_d;
         r_phase  <= w_phase_d;
         r_nxt    <= w_nxt_d;
         r_flash  <= w_flash_d;
         r_green  <= w_green_d;
         r_yellow <= w_yellow_d;
         r_red    <= w_red_d;
      end
   end

   // Next state, timer load, and lamp decode of the next state so lamps track state.
   always_comb begin
      w_state_d  = r_state;
      w_phase_d  = r_phase;
      w_nxt_d    = r_nxt;
      w_flash_d  = r_flash;
      w_load     = 1'b0;
      w_load_val = '0;
      w_green_d  = '0;
      w_yellow_d = '0;
      w_red_d    = '0;
      w_phase_oh = '0;

      if (NIGHT) begin
         w_state_d  = ST_FLASH;
         w_load     = 1'b1;
         w_load_val = '0;
         if (r_state != ST_FLASH) begin
            w_flash_d = 1'b1;
         end else if (TICK) begin
            w_flash_d = ~r_flash;
         end
      end else begin
         case (r_state)
            ST_GREEN: begin
               if (w_expire) begin
                  w_load = 1'b1;
                  if (w_other_req) begin
                     w_state_d  = ST_YELLOW;
                     w_load_val = TW'(Y_TIME);
                     w_nxt_d    = f_next_phase(REQ, r_phase);
                  end else begin
                     w_load_val = f_green_time(GREEN_T, r_phase);
                  end
               end
            end
            ST_YELLOW: begin
               if (w_expire) begin
                  w_state_d  = ST_ALLRED;
                  w_load     = 1'b1;
                  w_load_val = TW'(R_TIME);
               end
            end
            ST_ALLRED: begin
               if (w_expire) begin
                  w_state_d  = ST_GREEN;
                  w_phase_d  = r_nxt;
                  w_load     = 1'b1;
                  w_load_val = f_green_time(GREEN_T, r_nxt);
               end
            end
            ST_FLASH: begin
               w_state_d  = ST_ALLRED;
               w_nxt_d    = '0;
               w_flash_d  = 1'b0;
               w_load     = 1'b1;
               w_load_val = TW'(R_TIME);
            end
            default: ;
         endcase
      end

      w_phase_oh = N_PHASE'(phase_onehot(w_phase_d));
      case (w_state_d)
         ST_GREEN: begin
            w_green_d = w_phase_oh;
            w_red_d   = ~w_phase_oh;
         end
         ST_YELLOW: begin
            w_yellow_d = w_phase_oh;
            w_red_d    = ~w_phase_oh;
         end
         ST_ALLRED: w_red_d    = '1;
         ST_FLASH:  w_yellow_d = {N_PHASE{w_flash_d}};
         default: ;
      endcase
   end

   assign state  = r_state;
   assign phase  = r_phase;
   assign green  = r_green;
   assign yellow = r_yellow;
   assign red    = r_red;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: expected per-cycle outputs are
// queued with the stimulus and compared one cycle-sample at a time.
module tb_traffic_phase_ctrl;

   localparam int NP = 4;
   localparam int TW = 6;
   localparam logic [1:0] S_G = 2'b00;
   localparam logic [1:0] S_Y = 2'b01;
   localparam logic [1:0] S_A = 2'b10;
   localparam logic [1:0] S_F = 2'b11;

   typedef struct packed {
      logic [1:0]    st;
      logic [2:0]    ph;
      logic [TW-1:0] rem;
      logic [NP-1:0] g;
      logic [NP-1:0] y;
      logic [NP-1:0] r;
   } obs_t;

   logic             CLK = 1'b0;
   logic             RSTn;
   logic             TICK;
   logic             NIGHT;
   logic [NP-1:0]    REQ;
   logic [NP*TW-1:0] GREEN_T;
   logic [1:0]       state;
   logic [2:0]       phase;
   logic [TW-1:0]    remain;
   logic [NP-1:0]    green;
   logic [NP-1:0]    yellow;
   logic [NP-1:0]    red;

   obs_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 CLK = ~CLK;

   traffic_phase_ctrl #(
      .N_PHASE (NP),
      .TW      (TW),
      .Y_TIME  (3),
      .R_TIME  (1)
   ) dut (
      .CLK     (CLK),
      .RSTn    (RSTn),
      .TICK    (TICK),
      .REQ     (REQ),
      .GREEN_T (GREEN_T),
      .NIGHT   (NIGHT),
      .state   (state),
      .phase   (phase),
      .remain  (remain),
      .green   (green),
      .yellow  (yellow),
      .red     (red)
   );

   // Expected output word from the lamp rules for a given state.
   function automatic obs_t mk(logic [1:0] st, int ph, int rem, logic fl);
      obs_t          e;
      logic [NP-1:0] oh;
      oh    = NP'(1) << ph;
      e.st  = st;
      e.ph  = 3'(ph);
      e.rem = TW'(rem);
      e.g   = '0;
      e.y   = '0;
      e.r   = '0;
      case (st)
         S_G: begin e.g = oh; e.r = ~oh; end
         S_Y: begin e.y = oh; e.r = ~oh; end
         S_A: e.r = '1;
         default: e.y = {NP{fl}};
      endcase
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.st  = state;
      o.ph  = phase;
      o.rem = remain;
      o.g   = green;
      o.y   = yellow;
      o.r   = red;
      return o;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("st=%0d ph=%0d rem=%0d g=%b y=%b r=%b", o.st, o.ph, o.rem, o.g, o.y, o.r);
   endfunction

   task automatic push_green(int ph, int from);
      for (int t = from; t >= 1; t--) q.push_back(mk(S_G, ph, t, 1'b0));
   endtask

   task automatic push_yellow(int ph);
      for (int t = 3; t >= 1; t--) q.push_back(mk(S_Y, ph, t, 1'b0));
   endtask

   task automatic push_allred(int ph);
      q.push_back(mk(S_A, ph, 1, 1'b0));
   endtask

   task automatic test_reset();
      obs_t o, e;
      int   n;
      TICK    = 1'b1;
      NIGHT   = 1'b0;
      REQ     = '0;
      GREEN_T = {6'd8, 6'd7, 6'd6, 6'd5};
      push_allred(0);
      push_allred(0);
      push_allred(0);
      q.push_back(mk(S_G, 0, 5, 1'b0));
      n = q.size();
      for (int i = 0; i < n; i++) begin
         case (i)
            0: begin RSTn = 1'b1; #2; RSTn = 1'b0; #1; end
            1: begin REQ = '1; repeat (2) @(posedge CLK); #1; end
            2: begin @(negedge CLK); RSTn = 1'b1; REQ = '0; #1; end
            default: begin @(posedge CLK); #1; end
         endcase
         o = sample();
         e = q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset step=%0d got %s exp %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_hold();
      obs_t o, e;
      int   n;
      REQ = '0;
      push_green(0, 4);
      push_green(0, 5);
      n = q.size();
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
         o = sample();
         e = q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL hold cyc=%0d got %s exp %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_switch();
      obs_t o, e;
      int   n;
      REQ = 4'b1010;
      push_yellow(0);
      push_allred(0);
      push_green(1, 6);
      push_yellow(1);
      push_allred(1);
      q.push_back(mk(S_G, 3, 8, 1'b0));
      n = q.size();
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
         o = sample();
         e = q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL switch cyc=%0d got %s exp %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   // Early demand on phase 0 is replaced by phase 2 at expiry; later wrap to 0.
   task automatic test_wrap();
      obs_t o, e;
      int   n;
      push_green(3, 7);
      push_yellow(3);
      push_allred(3);
      q.push_back(mk(S_G, 2, 7, 1'b0));
      push_green(2, 6);
      push_yellow(2);
      push_allred(2);
      q.push_back(mk(S_G, 0, 5, 1'b0));
      push_green(0, 4);
      q.push_back(mk(S_G, 0, 5, 1'b0));
      n = q.size();
      for (int i = 0; i < n; i++) begin
         case (i)
            0: REQ = 4'b0001;
            7: REQ = 4'b0100;
            8: REQ = 4'b0001;
            default: ;
         endcase
         @(posedge CLK); #1;
         o = sample();
         e = q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL wrap cyc=%0d got %s exp %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_night();
      obs_t o, e;
      int   n;
      q.push_back(mk(S_G, 0, 4, 1'b0));
      q.push_back(mk(S_F, 0, 0, 1'b1));
      q.push_back(mk(S_F, 0, 0, 1'b0));
      q.push_back(mk(S_F, 0, 0, 1'b1));
      q.push_back(mk(S_F, 0, 0, 1'b1));
      q.push_back(mk(S_F, 0, 0, 1'b0));
      push_allred(0);
      push_green(0, 5);
      q.push_back(mk(S_F, 0, 0, 1'b1));
      push_allred(0);
      q.push_back(mk(S_G, 0, 5, 1'b0));
      q.push_back(mk(S_G, 0, 5, 1'b0));
      q.push_back(mk(S_G, 0, 4, 1'b0));
      n = q.size();
      for (int i = 0; i < n; i++) begin
         case (i)
            0:  REQ = '0;
            1:  NIGHT = 1'b1;
            4:  TICK = 1'b0;
            5:  TICK = 1'b1;
            6:  NIGHT = 1'b0;
            12: begin REQ = 4'b0010; NIGHT = 1'b1; end
            13: NIGHT = 1'b0;
            15: TICK = 1'b0;
            16: TICK = 1'b1;
            default: ;
         endcase
         @(posedge CLK); #1;
         o = sample();
         e = q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL night cyc=%0d got %s exp %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_reset_mid();
      obs_t o, e;
      int   n;
      push_green(0, 3);
      push_yellow(0);
      push_allred(0);
      q.push_back(mk(S_G, 2, 7, 1'b0));
      push_green(2, 6);
      q.push_back(mk(S_Y, 2, 3, 1'b0));
      q.push_back(mk(S_Y, 2, 2, 1'b0));
      push_allred(0);
      q.push_back(mk(S_G, 0, 5, 1'b0));
      n = q.size();
      for (int i = 0; i < n; i++) begin
         case (i)
            0:  begin REQ = 4'b0100; @(posedge CLK); #1; end
            8:  begin REQ = 4'b0001; @(posedge CLK); #1; end
            16: begin #2; RSTn = 1'b0; #1; end
            17: begin @(negedge CLK); RSTn = 1'b1; @(posedge CLK); #1; end
            default: begin @(posedge CLK); #1; end
         endcase
         o = sample();
         e = q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid step=%0d got %s exp %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   initial begin
      test_reset();
      test_hold();
      test_switch();
      test_wrap();
      test_night();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
